// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared defaults and types for the CPU I/O port peripheral.
//   DEF_WIDTH / DEF_DEPTH : default data width and FIFO depth
//   PTR_W / CNT_W         : pointer and occupancy-count widths for DEF_DEPTH
//   err_flags_t           : sticky error flags raised by the CPU side
// -----------------------------------------------------------------------------
package io_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 32;
  localparam int PTR_W     = $clog2(DEF_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef struct packed {
    logic underflow;  // CPU read while the input queue was empty
    logic overflow;   // CPU write while the output queue was full
  } err_flags_t;

endpackage : io_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO with an explicit occupancy counter.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push_data : value written when a push is accepted
//   push      : request to enqueue push_data this cycle
//   pop       : request to dequeue the head this cycle (ignored when empty)
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : number of stored entries, 0..DEPTH
//   head      : storage at the read pointer (not masked; caller masks on empty)
// A push while full is accepted only if a pop retires the head in the same
// cycle, so a full FIFO can stream at one entry per clock.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = io_pkg::DEF_WIDTH,
  parameter int DEPTH = io_pkg::DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     push,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty come from the counter, so wr_ptr == rd_ptr is never ambiguous.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop);

  assign head = mem[rd_ptr];

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values; blocking here would race between
  // the count, pointer and memory updates within the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly PTR_W bits, so they wrap modulo DEPTH.
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // NOTE: the storage array is deliberately not reset; a stale entry can
  // never be observed because head is masked by the caller while empty and
  // the counter gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= push_data;
  end

endmodule : sync_fifo

// File: rtl/cpu_io_port.sv
// -----------------------------------------------------------------------------
// cpu_io_port
// Peripheral on the far side of the CPU I/O interface. A host preloads values
// into the input queue (read by the CPU through cpu_I/cpu_IEnable) and drains
// the output queue (written by the CPU through cpu_O/cpu_OEnable).
//   clk, rst        : clock, synchronous active-high reset
//   host_in_data    : value to enqueue toward the CPU
//   host_in_push    : enqueue host_in_data this cycle
//   host_in_full    : input queue holds DEPTH entries
//   host_in_count   : input queue occupancy
//   host_out_data   : output queue head, 0 when empty
//   host_out_pop    : dequeue output head this cycle
//   host_out_empty  : output queue empty
//   host_out_count  : output queue occupancy
//   cpu_I           : input queue head, 0 when empty
//   cpu_IEnable     : CPU consumes cpu_I this cycle
//   cpu_O           : CPU output value
//   cpu_OEnable     : capture cpu_O this cycle
//   underflow       : sticky, CPU read while input queue empty
//   overflow        : sticky, CPU write dropped because output queue full
// -----------------------------------------------------------------------------
module cpu_io_port
  import io_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       host_in_data,
  input  logic                   host_in_push,
  output logic                   host_in_full,
  output logic [$clog2(DEPTH):0] host_in_count,
  output logic [WIDTH-1:0]       host_out_data,
  input  logic                   host_out_pop,
  output logic                   host_out_empty,
  output logic [$clog2(DEPTH):0] host_out_count,
  output logic [WIDTH-1:0]       cpu_I,
  input  logic                   cpu_IEnable,
  input  logic [WIDTH-1:0]       cpu_O,
  input  logic                   cpu_OEnable,
  output logic                   underflow,
  output logic                   overflow
);

  logic             in_empty;
  logic [WIDTH-1:0] in_head;
  logic             out_full;
  logic [WIDTH-1:0] out_head;
  err_flags_t       flags;

  // Host -> CPU queue. The CPU read strobe is the pop.
  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_in_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_data (host_in_data),
    .push      (host_in_push),
    .pop       (cpu_IEnable),
    .full      (host_in_full),
    .empty     (in_empty),
    .count     (host_in_count),
    .head      (in_head)
  );

  // CPU -> host queue. The CPU write strobe is the push.
  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_data (cpu_O),
    .push      (cpu_OEnable),
    .pop       (host_out_pop),
    .full      (out_full),
    .empty     (host_out_empty),
    .count     (host_out_count),
    .head      (out_head)
  );

  // Heads depend only on registered pointers/counts, so neither strobe has a
  // combinational path to the data it consumes.
  assign cpu_I         = in_empty       ? '0 : in_head;
  assign host_out_data = host_out_empty ? '0 : out_head;

  // A write into a full queue is only lost when the host is not popping in
  // the same cycle; a read from an empty queue is always an underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= '0;
    end else begin
      if (cpu_IEnable && in_empty)                   flags.underflow <= 1'b1;
      if (cpu_OEnable && out_full && !host_out_pop)  flags.overflow  <= 1'b1;
    end
  end

  assign underflow = flags.underflow;
  assign overflow  = flags.overflow;

endmodule : cpu_io_port

// File: tb/tb_cpu_io_port.sv
// -----------------------------------------------------------------------------
// tb_cpu_io_port
// Self-checking bench for cpu_io_port. A queue-based model of both FIFOs and
// the sticky flags is advanced once per clock and every DUT output is compared
// against it one time unit after the rising edge. Directed phases follow the
// documented scenarios; a randomized phase mixes all strobes.
// -----------------------------------------------------------------------------
module tb_cpu_io_port;

  localparam int W  = 8;
  localparam int D  = 32;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  host_in_data;
  logic          host_in_push;
  logic          host_in_full;
  logic [CW-1:0] host_in_count;
  logic [W-1:0]  host_out_data;
  logic          host_out_pop;
  logic          host_out_empty;
  logic [CW-1:0] host_out_count;
  logic [W-1:0]  cpu_I;
  logic          cpu_IEnable;
  logic [W-1:0]  cpu_O;
  logic          cpu_OEnable;
  logic          underflow;
  logic          overflow;

  always #5 clk = ~clk;

  cpu_io_port #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .host_in_data   (host_in_data),
    .host_in_push   (host_in_push),
    .host_in_full   (host_in_full),
    .host_in_count  (host_in_count),
    .host_out_data  (host_out_data),
    .host_out_pop   (host_out_pop),
    .host_out_empty (host_out_empty),
    .host_out_count (host_out_count),
    .cpu_I          (cpu_I),
    .cpu_IEnable    (cpu_IEnable),
    .cpu_O          (cpu_O),
    .cpu_OEnable    (cpu_OEnable),
    .underflow      (underflow),
    .overflow       (overflow)
  );

  // Reference model: plain queues plus two sticky bits.
  logic [W-1:0] in_q[$];
  logic [W-1:0] out_q[$];
  bit           m_uf;
  bit           m_of;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] m_in_head();
    return (in_q.size() > 0) ? in_q[0] : '0;
  endfunction

  function automatic logic [W-1:0] m_out_head();
    return (out_q.size() > 0) ? out_q[0] : '0;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ":cpu_I"},          32'(cpu_I),          32'(m_in_head()));
    check({tag, ":in_count"},       32'(host_in_count),  in_q.size());
    check({tag, ":in_full"},        32'(host_in_full),   32'(in_q.size() == D));
    check({tag, ":out_data"},       32'(host_out_data),  32'(m_out_head()));
    check({tag, ":out_count"},      32'(host_out_count), out_q.size());
    check({tag, ":out_empty"},      32'(host_out_empty), 32'(out_q.size() == 0));
    check({tag, ":underflow"},      32'(underflow),      32'(m_uf));
    check({tag, ":overflow"},       32'(overflow),       32'(m_of));
  endtask

  // One clock: drive inputs after the falling edge, advance the model at the
  // rising edge, compare one time unit later.
  task automatic step(input string tag, input bit r, input bit push, input logic [W-1:0] din,
                      input bit ien, input bit oen, input logic [W-1:0] o, input bit pop);
    bit in_full_m, in_empty_m, out_full_m, out_empty_m;
    @(negedge clk);
    rst          = r;
    host_in_push = push;
    host_in_data = din;
    cpu_IEnable  = ien;
    cpu_OEnable  = oen;
    cpu_O        = o;
    host_out_pop = pop;
    @(posedge clk);
    if (r) begin
      in_q.delete();
      out_q.delete();
      m_uf = 1'b0;
      m_of = 1'b0;
    end else begin
      in_full_m   = (in_q.size() == D);
      in_empty_m  = (in_q.size() == 0);
      out_full_m  = (out_q.size() == D);
      out_empty_m = (out_q.size() == 0);
      if (ien && in_empty_m) m_uf = 1'b1;
      if (ien && !in_empty_m) void'(in_q.pop_front());
      if (push && (!in_full_m || ien)) in_q.push_back(din);
      if (oen && out_full_m && !pop) m_of = 1'b1;
      if (pop && !out_empty_m) void'(out_q.pop_front());
      if (oen && (!out_full_m || pop)) out_q.push_back(o);
    end
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    step("reset", 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] v;
    rst = 1'b1; host_in_data = '0; host_in_push = 1'b0; cpu_IEnable = 1'b0;
    cpu_O = '0; cpu_OEnable = 1'b0; host_out_pop = 1'b0;

    // Reset state.
    do_reset();
    check("rst_cpu_I", 32'(cpu_I), 32'h0);
    check("rst_out_empty", 32'(host_out_empty), 32'h1);
    idle("idle0");

    // Fill input queue with 0..31, then a dropped 0xFF, then drain.
    for (int i = 0; i < D; i++) step("in_fill", 1'b0, 1'b1, W'(i), 1'b0, 1'b0, '0, 1'b0);
    check("in_full_at_32", 32'(host_in_full), 32'h1);
    check("in_count_32", 32'(host_in_count), 32'd32);
    step("in_drop", 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, '0, 1'b0);
    check("in_count_after_drop", 32'(host_in_count), 32'd32);
    for (int i = 0; i < D; i++) begin
      check("in_order", 32'(cpu_I), 32'(i));
      step("in_drain", 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    end
    check("in_empty_zero", 32'(cpu_I), 32'h0);
    check("no_underflow_yet", 32'(underflow), 32'h0);

    // Output queue: 0x10..0x2F, 33rd write overflows, then drain.
    for (int i = 0; i < D; i++) step("out_fill", 1'b0, 1'b0, '0, 1'b0, 1'b1, W'(8'h10 + i), 1'b0);
    check("out_count_32", 32'(host_out_count), 32'd32);
    step("out_over", 1'b0, 1'b0, '0, 1'b0, 1'b1, 8'h77, 1'b0);
    check("overflow_set", 32'(overflow), 32'h1);
    for (int i = 0; i < D; i++) begin
      check("out_order", 32'(host_out_data), 32'(8'h10 + i));
      step("out_drain", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    end
    check("out_empty_after", 32'(host_out_empty), 32'h1);
    step("out_pop_empty", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

    // Underflow on empty input queue; sticky until reset.
    step("underflow", 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("underflow_set", 32'(underflow), 32'h1);
    for (int i = 0; i < 4; i++) idle("uf_hold");
    check("underflow_sticky", 32'(underflow), 32'h1);
    do_reset();
    check("flags_cleared", 32'({underflow, overflow}), 32'h0);

    // Simultaneous push+pop on empty: underflow and the push still lands.
    step("pp_empty", 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, '0, 1'b0);
    check("pp_empty_landed", 32'(cpu_I), 32'h5A);
    do_reset();

    // Full input queue, push 0xAA with a pop; 0xAA reaches the head 31 pops later.
    for (int i = 0; i < D; i++) step("wrap_fill", 1'b0, 1'b1, W'($urandom), 1'b0, 1'b0, '0, 1'b0);
    step("full_pp", 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, '0, 1'b0);
    check("full_pp_count", 32'(host_in_count), 32'd32);
    for (int i = 0; i < D - 1; i++) step("wrap_stream", 1'b0, 1'b1, W'($urandom), 1'b1, 1'b0, '0, 1'b0);
    check("aa_emerges", 32'(cpu_I), 32'hAA);
    // Three more laps of streaming on both queues.
    for (int i = 0; i < 3 * D; i++)
      step("wrap_laps", 1'b0, 1'b1, W'($urandom), 1'b1, 1'b1, W'($urandom), ($urandom_range(0, 1) == 1));
    do_reset();

    // Randomized mixed traffic, biased so both queues visit full and empty.
    for (int i = 0; i < 600; i++) begin
      int phase;
      phase = (i / 75) % 2;
      step("random", ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) < (phase ? 1 : 3)), W'($urandom),
           ($urandom_range(0, 3) < (phase ? 3 : 1)),
           ($urandom_range(0, 3) < (phase ? 1 : 3)), W'($urandom),
           ($urandom_range(0, 3) < (phase ? 3 : 1)));
    end

    // Echo loop: host streams in, CPU copies I->O, reset after 10 echoes.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      v = m_in_head();
      step("echo_a", 1'b0, 1'b1, W'($urandom), (in_q.size() > 0), (in_q.size() > 0), v, 1'b0);
    end
    do_reset();
    check("echo_rst_in", 32'(host_in_count), 32'h0);
    check("echo_rst_out", 32'(host_out_count), 32'h0);
    for (int i = 0; i < D + 2; i++) begin
      v = m_in_head();
      step("echo_b", 1'b0, (i < D), W'(8'hC0 + i), (in_q.size() > 0), (in_q.size() > 0), v, 1'b0);
    end
    for (int i = 0; i < D; i++) begin
      check("echo_out", 32'(host_out_data), 32'(8'hC0 + i));
      step("echo_drain", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    end
    check("echo_clean", 32'({underflow, overflow}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cpu_io_port
